// File: rtl/rr_arb_pkg.sv
// Shared types and width helpers for the round-robin burst arbiter.
package rr_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Index/counter width for a range of v values; never below one bit.
  function automatic int clog2w(input int v);
    int r;
    if (v <= 2) begin
      r = 1;
    end else begin
      r = $clog2(v);
    end
    return r;
  endfunction

endpackage : rr_arb_pkg

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first asserted request at or after ptr, wrapping.
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IDW = clog2w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [IDW-1:0]   idx,
  output logic             any
);

  logic [2*N_REQ-1:0] req2_s;
  logic [2*N_REQ-1:0] mask_s;
  logic [2*N_REQ-1:0] masked_s;

  // Duplicating the vector lets one forward scan cover the wrap-around.
  always_comb begin
    req2_s   = {req, req};
    mask_s   = {(2*N_REQ){1'b1}} << ptr;
    masked_s = req2_s & mask_s;
  end

  // Lowest set bit of the masked double-width vector, folded back into range.
  always_comb begin
    logic found;
    found = 1'b0;
    idx   = '0;
    any   = |req;
    for (int i = 0; i < 2*N_REQ; i++) begin
      if (masked_s[i] && !found) begin
        found = 1'b1;
        if (i >= N_REQ) begin
          idx = IDW'(i - N_REQ);
        end else begin
          idx = IDW'(i);
        end
      end else begin
        found = found;
      end
    end
  end

endmodule : rr_pick

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter granting one requester at a time a burst on a shared
// valid/ready sink; a burst ends on last, on the beat limit, or on a stall.
module rr_burst_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int MAX_BURST     = 16,
  parameter int STALL_TIMEOUT = 8,
  localparam int IDW = clog2w(N_REQ),
  localparam int BW  = clog2w(MAX_BURST),
  localparam int TW  = clog2w(STALL_TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_valid,
  input  logic [N_REQ-1:0] req_last,
  output logic [N_REQ-1:0] req_ready,
  input  logic [BW-1:0]    burst_limit,
  input  logic             out_ready,
  output logic             out_valid,
  output logic             out_last,
  output logic [IDW-1:0]   grant_id,
  output logic [N_REQ-1:0] grant_onehot,
  output logic             busy
);

  localparam logic [N_REQ-1:0] ONE_LSB = {{(N_REQ-1){1'b0}}, 1'b1};

  arb_state_e       state_q,        state_d;
  logic [IDW-1:0]   ptr_q,          ptr_d;
  logic [IDW-1:0]   grant_id_q,     grant_id_d;
  logic [N_REQ-1:0] grant_onehot_q, grant_onehot_d;
  logic [BW-1:0]    beat_cnt_q,     beat_cnt_d;
  logic [TW-1:0]    stall_cnt_q,    stall_cnt_d;
  logic [BW-1:0]    lim_q,          lim_d;

  logic [IDW-1:0]   pick_idx_s;
  logic             pick_any_s;
  logic             granted_s;
  logic             g_valid_s;
  logic             g_last_s;
  logic             at_lim_s;
  logic             beat_s;
  logic             end_s;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req (req_valid),
    .ptr (ptr_q),
    .idx (pick_idx_s),
    .any (pick_any_s)
  );

  // Owner-side view of the handshake; reset masks everything so no beat lands in it.
  always_comb begin
    granted_s = (state_q == GRANT) && !rst;
    g_valid_s = req_valid[grant_id_q];
    g_last_s  = req_last[grant_id_q];
    at_lim_s  = (beat_cnt_q == lim_q);
    beat_s    = granted_s & g_valid_s & out_ready;
    end_s     = (beat_s & (g_last_s | at_lim_s))
              | (granted_s & ~g_valid_s & (stall_cnt_q == TW'(STALL_TIMEOUT - 1)));
  end

  // Downstream and requester-facing outputs.
  always_comb begin
    busy         = granted_s;
    out_valid    = granted_s & g_valid_s;
    out_last     = granted_s & g_valid_s & (g_last_s | at_lim_s);
    req_ready    = granted_s ? (grant_onehot_q & {N_REQ{out_ready}}) : {N_REQ{1'b0}};
    grant_id     = grant_id_q;
    grant_onehot = grant_onehot_q;
  end

  // Next-state, pointer and counter logic.
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    grant_id_d     = grant_id_q;
    grant_onehot_d = grant_onehot_q;
    beat_cnt_d     = beat_cnt_q;
    stall_cnt_d    = stall_cnt_q;
    lim_d          = lim_q;
    case (state_q)
      IDLE: begin
        if (pick_any_s) begin
          state_d        = GRANT;
          grant_id_d     = pick_idx_s;
          grant_onehot_d = ONE_LSB << pick_idx_s;
          lim_d          = burst_limit;
          beat_cnt_d     = '0;
          stall_cnt_d    = '0;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (beat_s) begin
          beat_cnt_d  = beat_cnt_q + BW'(1);
          stall_cnt_d = '0;
        end else if (!g_valid_s) begin
          stall_cnt_d = stall_cnt_q + TW'(1);
        end else begin
          stall_cnt_d = stall_cnt_q;
        end
        // Explicit wrap keeps non-power-of-two N_REQ in range.
        if (end_s) begin
          state_d        = IDLE;
          grant_onehot_d = '0;
          if (grant_id_q == IDW'(N_REQ - 1)) begin
            ptr_d = '0;
          end else begin
            ptr_d = grant_id_q + IDW'(1);
          end
        end else begin
          state_d = GRANT;
        end
      end
      default: begin
        state_d        = IDLE;
        grant_onehot_d = '0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      ptr_q          <= '0;
      grant_id_q     <= '0;
      grant_onehot_q <= '0;
      beat_cnt_q     <= '0;
      stall_cnt_q    <= '0;
      lim_q          <= '0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      grant_id_q     <= grant_id_d;
      grant_onehot_q <= grant_onehot_d;
      beat_cnt_q     <= beat_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
      lim_q          <= lim_d;
    end
  end

endmodule : rr_burst_arbiter
